// File: rtl/dmux_4way_pkg.sv
// dmux_4way_pkg: shared types and constants for the 1-to-4 registered demux.
// Optional feature macro used by the top: DMUX_4WAY_STATS_EN.
package dmux_4way_pkg;

    // Destination select encoding
    typedef enum logic [1:0] {
        SEL_A = 2'b00,
        SEL_B = 2'b01,
        SEL_C = 2'b10,
        SEL_D = 2'b11
    } sel_e;

    localparam int unsigned NUM_CH         = 4;
    localparam int unsigned DEFAULT_WIDTH  = 1;
    localparam int unsigned DEFAULT_STAT_W = 16;

endpackage : dmux_4way_pkg

// File: rtl/dmux_4way_decode.sv
// dmux_4way_decode: pure combinational 2-to-4 one-hot decoder.
// An unknown select falls through to all-zero so no channel is enabled.
module dmux_4way_decode
    import dmux_4way_pkg::*;
(
    input  sel_e              sel_i,
    output logic [NUM_CH-1:0] onehot_o
);

    // One-hot decode of the select; default keeps every channel off
    always_comb begin
        onehot_o = '0;
        case (sel_i)
            SEL_A:   onehot_o = 4'b0001;
            SEL_B:   onehot_o = 4'b0010;
            SEL_C:   onehot_o = 4'b0100;
            SEL_D:   onehot_o = 4'b1000;
            default: onehot_o = '0;
        endcase
    end

endmodule : dmux_4way_decode

// File: rtl/dmux_4way.sv
// dmux_4way: 1-to-4 demultiplexer with a registered output stage.
// The input word goes to the channel picked by sel one clock later; the
// other three channels read zero. Define DMUX_4WAY_STATS_EN to add
// saturating per-channel counters of non-zero words (stat_a..stat_d).
module dmux_4way
    import dmux_4way_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAT_W = DEFAULT_STAT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in,
    input  logic [1:0]        sel,
    output logic [WIDTH-1:0]  a,
    output logic [WIDTH-1:0]  b,
    output logic [WIDTH-1:0]  c,
    output logic [WIDTH-1:0]  d
`ifdef DMUX_4WAY_STATS_EN
   ,output logic [STAT_W-1:0] stat_a,
    output logic [STAT_W-1:0] stat_b,
    output logic [STAT_W-1:0] stat_c,
    output logic [STAT_W-1:0] stat_d
`endif
);

    logic [NUM_CH-1:0]            onehot;
    logic [NUM_CH-1:0][WIDTH-1:0] ch_d;
    logic [NUM_CH-1:0][WIDTH-1:0] ch_q;

    dmux_4way_decode u_decode (
        .sel_i    (sel_e'(sel)),
        .onehot_o (onehot)
    );

    // Gate the input word onto the selected channel only
    always_comb begin
        ch_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_d[i] = {WIDTH{onehot[i]}} & in;
        end
    end

    // Output registers; reset clears them without waiting for a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q <= '0;
        end else begin
            ch_q <= ch_d;
        end
    end

    assign a = ch_q[0];
    assign b = ch_q[1];
    assign c = ch_q[2];
    assign d = ch_q[3];

`ifdef DMUX_4WAY_STATS_EN
    logic [NUM_CH-1:0][STAT_W-1:0] stat_d_n;
    logic [NUM_CH-1:0][STAT_W-1:0] stat_q;
    logic                          in_nz;

    assign in_nz = |in;

    // Bump the selected channel's count for non-zero words, holding at all-ones
    always_comb begin
        stat_d_n = stat_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (onehot[i] && in_nz && (stat_q[i] != {STAT_W{1'b1}})) begin
                stat_d_n[i] = stat_q[i] + 1'b1;
            end
        end
    end

    // Counter registers, cleared together with the datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else begin
            stat_q <= stat_d_n;
        end
    end

    assign stat_a = stat_q[0];
    assign stat_b = stat_q[1];
    assign stat_c = stat_q[2];
    assign stat_d = stat_q[3];
`endif

endmodule : dmux_4way

// File: tb/tb_dmux_4way.sv
// tb_dmux_4way: directed bench with an expected-value queue for dmux_4way.
module tb_dmux_4way;

    localparam int W = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] in    = '0;
    logic [1:0]   sel   = '0;
    logic [W-1:0] a, b, c, d;

    int errors = 0;
    int checks = 0;

    logic [4*W-1:0] exp_q[$];

`ifdef DMUX_4WAY_STATS_EN
    logic [15:0] stat_a, stat_b, stat_c, stat_d;
    logic [1:0]  sat_a, sat_b, sat_c, sat_d;
    logic [W-1:0] sa, sb, sc, sd;
`endif

    dmux_4way #(.WIDTH(W), .STAT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .sel   (sel),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d)
`ifdef DMUX_4WAY_STATS_EN
       ,.stat_a(stat_a),
        .stat_b(stat_b),
        .stat_c(stat_c),
        .stat_d(stat_d)
`endif
    );

`ifdef DMUX_4WAY_STATS_EN
    dmux_4way #(.WIDTH(W), .STAT_W(2)) dut_sat (
        .clk    (clk),
        .rst_n  (rst_n),
        .in     (in),
        .sel    (sel),
        .a      (sa),
        .b      (sb),
        .c      (sc),
        .d      (sd),
        .stat_a (sat_a),
        .stat_b (sat_b),
        .stat_c (sat_c),
        .stat_d (sat_d)
    );
`endif

    always #5 clk = ~clk;

    function automatic logic [4*W-1:0] model(input logic [W-1:0] din, input logic [1:0] s);
        logic [4*W-1:0] r;
        r = '0;
        if (s == 2'd0) r[4*W-1:3*W] = din;
        if (s == 2'd1) r[3*W-1:2*W] = din;
        if (s == 2'd2) r[2*W-1:W]   = din;
        if (s == 2'd3) r[W-1:0]     = din;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one word at the falling edge, expect it on {a,b,c,d} after the next rise
    task automatic step(input string tag, input logic [W-1:0] din, input logic [1:0] s);
        logic [4*W-1:0] e;
        in  = din;
        sel = s;
        exp_q.push_back(model(din, s));
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 64'({a, b, c, d}), 64'(e));
        end
        @(negedge clk);
    endtask

    initial begin
        // Asynchronous reset before any clock edge
        in  = 4'd1;
        sel = 2'b00;
        #1 rst_n = 1'b0;
        #1 chk("async_reset", 64'({a, b, c, d}), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 chk("reset_hold", 64'({a, b, c, d}), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Zero data on every select
        for (int s = 0; s < 4; s++) step("zero_sweep", '0, 2'(s));

        // One-hot walk of in=1 through each channel
        step("one_a", 4'd1, 2'b00);
        chk("one_a_only", 64'({a, b, c, d}), 64'h1000);
        step("one_b", 4'd1, 2'b01);
        step("one_c", 4'd1, 2'b10);
        step("one_d", 4'd1, 2'b11);

        // Latency and no-hold: a then d
        step("lat_a", 4'd1, 2'b00);
        step("lat_d", 4'd1, 2'b11);

        // Wide data patterns
        step("pat_a", 4'hA, 2'b00);
        step("pat_b", 4'h5, 2'b01);
        step("pat_c", 4'hF, 2'b10);
        step("pat_d", 4'h8, 2'b11);
        for (int i = 0; i < 16; i++)
            step("rand", 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));

        // Reset mid-stream clears c at once
        step("mid_c1", 4'd1, 2'b10);
        step("mid_c2", 4'd1, 2'b10);
        #2 rst_n = 1'b0;
        #1 chk("mid_reset", 64'({a, b, c, d}), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset_c", 4'd1, 2'b10);
        chk("post_reset_c_val", 64'(c), 64'd1);

`ifdef DMUX_4WAY_STATS_EN
        // Counter check from a clean reset
        rst_n = 1'b0;
        #1 chk("stat_reset", 64'({stat_a, stat_b, stat_c, stat_d}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step("stat_cnt", 4'hF, 2'b01);
        for (int i = 0; i < 2; i++) step("stat_zero", 4'h0, 2'b01);
        chk("stat_b", 64'(stat_b), 64'd5);
        chk("stat_others", 64'({stat_a, stat_c, stat_d}), 64'd0);
        chk("stat_sat_b", 64'(sat_b), 64'd3);
        chk("stat_sat_others", 64'({sat_a, sat_c, sat_d}), 64'd0);
`endif

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_dmux_4way
